// File: rtl/encoder_4_2_buffered_if.sv
// encoder_4_2_buffered_if
//   Bundles the upstream sample handshake and the downstream code handshake
//   of encoder_4_2_buffered, together with its status outputs.
//
//   Handshake rules for both channels (valid/ready):
//     - A transfer happens on a rising clock edge where valid && ready are both 1.
//     - The producer holds valid and its data stable until that transfer.
//     - valid never depends on ready. Data_Ready_Out depends only on the FIFO
//       level and on reset.
//
//   Modports:
//     slave  : the encoder side (it consumes samples and produces codes)
//     master : the environment side (it drives samples and accepts codes)
//
//   Signals:
//     Data_Valid_In, Data_A_In..Data_D_In  upstream sample and its valid
//     Data_Ready_Out                        encoder can take a sample
//     Encoded_Value_Out, Encoded_Valid_Out  code at the FIFO head
//     Encoded_Ready_In                      downstream takes the head code
//     Multi_Hot_Out, Zero_Hot_Out           one-cycle error pulses
//     Error_Count_Out                       saturating error count
//     Fifo_Level_Out                        buffered entries, 0..FIFO_DEPTH
interface encoder_4_2_buffered_if #(
  parameter int FIFO_DEPTH    = 4,
  parameter int ERR_CNT_WIDTH = 8
);
  logic                           Data_Valid_In;
  logic                           Data_Ready_Out;
  logic                           Data_A_In;
  logic                           Data_B_In;
  logic                           Data_C_In;
  logic                           Data_D_In;
  logic [1:0]                     Encoded_Value_Out;
  logic                           Encoded_Valid_Out;
  logic                           Encoded_Ready_In;
  logic                           Multi_Hot_Out;
  logic                           Zero_Hot_Out;
  logic [ERR_CNT_WIDTH-1:0]       Error_Count_Out;
  logic [$clog2(FIFO_DEPTH):0]    Fifo_Level_Out;

  modport slave (
    input  Data_Valid_In, Data_A_In, Data_B_In, Data_C_In, Data_D_In,
    input  Encoded_Ready_In,
    output Data_Ready_Out, Encoded_Value_Out, Encoded_Valid_Out,
    output Multi_Hot_Out, Zero_Hot_Out, Error_Count_Out, Fifo_Level_Out
  );

  modport master (
    output Data_Valid_In, Data_A_In, Data_B_In, Data_C_In, Data_D_In,
    output Encoded_Ready_In,
    input  Data_Ready_Out, Encoded_Value_Out, Encoded_Valid_Out,
    input  Multi_Hot_Out, Zero_Hot_Out, Error_Count_Out, Fifo_Level_Out
  );
endinterface

// File: rtl/encoder_4_2_buffered.sv
// encoder_4_2_buffered
//   Registered 4-to-2 priority encoder (A=00, B=01, C=10, D=11, A has the
//   highest priority) with a FIFO of encoded codes on its output.
//   A sample with no line high is consumed and flagged, but nothing is pushed.
//   A sample with several lines high is flagged and pushes the code of its
//   highest-priority line.
//
//   Optional build macro STRICT_ONEHOT_EN: when defined, multi-hot samples
//   are consumed and flagged but not pushed, just like zero-hot samples.
//
//   Ports:
//     Clk_In    rising-edge clock
//     Reset_In  synchronous active-high reset
//     bus       encoder_4_2_buffered_if.slave (both handshakes plus status)
//
//   Parameters:
//     FIFO_DEPTH     buffered codes, power of 2, >= 2
//     ERR_CNT_WIDTH  width of the saturating error counter
module encoder_4_2_buffered #(
  parameter int FIFO_DEPTH    = 4,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                     Clk_In,
  input  logic                     Reset_In,
  encoder_4_2_buffered_if.slave    bus
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);

  logic [1:0]               mem [FIFO_DEPTH];
  logic [PW-1:0]            wr_ptr;
  logic [PW-1:0]            rd_ptr;
  logic [PW-1:0]            rd_next;
  logic [LW-1:0]            level;
  logic [1:0]               head;
  logic                     multi_q;
  logic                     zero_q;
  logic [ERR_CNT_WIDTH-1:0] err_cnt;

  logic [2:0] ones;
  logic       is_zero;
  logic       is_multi;
  logic [1:0] code;
  logic       ready;
  logic       accept;
  logic       push;
  logic       pop;

  always_comb begin
    ones     = {2'b00, bus.Data_A_In} + {2'b00, bus.Data_B_In}
             + {2'b00, bus.Data_C_In} + {2'b00, bus.Data_D_In};
    is_zero  = (ones == 3'd0);
    is_multi = (ones > 3'd1);
    code     = 2'b11;
    if (bus.Data_A_In)      code = 2'b00;
    else if (bus.Data_B_In) code = 2'b01;
    else if (bus.Data_C_In) code = 2'b10;
  end

  // Ready is held low while reset is asserted. When the FIFO is full, ready
  // stays low even if a pop happens in the same cycle, so a push is not
  // admitted on that edge.
  assign ready   = !Reset_In && (level != FULL_LVL);
  assign accept  = bus.Data_Valid_In && ready;
  assign pop     = (level != '0) && bus.Encoded_Ready_In;
  assign rd_next = rd_ptr + 1'b1;

`ifdef STRICT_ONEHOT_EN
  assign push = accept && (ones == 3'd1);
`else
  assign push = accept && !is_zero;
`endif

  // Storage has no reset. Entries are only read after they have been written.
  always_ff @(posedge Clk_In) begin
    if (push) mem[wr_ptr] <= code;
  end

  always_ff @(posedge Clk_In) begin
    if (Reset_In) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      head    <= 2'b00;
      multi_q <= 1'b0;
      zero_q  <= 1'b0;
      err_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_next;

      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase

      // The head register changes only when the code at the FIFO head moves.
      // If a pop leaves the FIFO empty, the last code stays on the output.
      if (pop) begin
        if (level > LW'(1))  head <= mem[rd_next];
        else if (push)       head <= code;
      end else if (push && (level == '0)) begin
        head <= code;
      end

      multi_q <= accept && is_multi;
      zero_q  <= accept && is_zero;
      if (accept && (is_multi || is_zero) && (err_cnt != '1))
        err_cnt <= err_cnt + 1'b1;
    end
  end

  assign bus.Data_Ready_Out    = ready;
  assign bus.Encoded_Value_Out = head;
  assign bus.Encoded_Valid_Out = (level != '0);
  assign bus.Multi_Hot_Out     = multi_q;
  assign bus.Zero_Hot_Out      = zero_q;
  assign bus.Error_Count_Out   = err_cnt;
  assign bus.Fifo_Level_Out    = level;

endmodule

// File: tb/tb_encoder_4_2_buffered.sv
// tb_encoder_4_2_buffered
//   Directed bench for encoder_4_2_buffered (FIFO_DEPTH=4, ERR_CNT_WIDTH=8).
//   A queue model of the FIFO, an error counter and expected pulses are
//   checked against the DUT on every falling edge. Literal expectations
//   pin key points of the directed sequence.
module tb_encoder_4_2_buffered;
  localparam int DEPTH   = 4;
  localparam int CW      = 8;
  localparam int CNT_MAX = (1 << CW) - 1;
`ifdef STRICT_ONEHOT_EN
  localparam int MH_LVL = 0;
`else
  localparam int MH_LVL = 1;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  encoder_4_2_buffered_if #(.FIFO_DEPTH(DEPTH), .ERR_CNT_WIDTH(CW)) bus();

  encoder_4_2_buffered #(.FIFO_DEPTH(DEPTH), .ERR_CNT_WIDTH(CW)) dut (
    .Clk_In  (clk),
    .Reset_In(rst),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  logic [1:0] exp_q[$];
  int         exp_cnt   = 0;
  bit         exp_multi = 1'b0;
  bit         exp_zero  = 1'b0;
  logic [1:0] last_val  = 2'b00;

  always @(posedge clk) begin
    int  n;
    bit  acc;
    bit  do_push;
    logic [1:0] c;
    if (rst) begin
      exp_q.delete();
      exp_cnt   = 0;
      exp_multi = 1'b0;
      exp_zero  = 1'b0;
      last_val  = 2'b00;
    end else begin
      n   = int'(bus.Data_A_In) + int'(bus.Data_B_In) + int'(bus.Data_C_In) + int'(bus.Data_D_In);
      acc = bus.Data_Valid_In && (exp_q.size() < DEPTH);
      c   = bus.Data_A_In ? 2'd0 : bus.Data_B_In ? 2'd1 : bus.Data_C_In ? 2'd2 : 2'd3;
`ifdef STRICT_ONEHOT_EN
      do_push = acc && (n == 1);
`else
      do_push = acc && (n > 0);
`endif
      exp_multi = acc && (n > 1);
      exp_zero  = acc && (n == 0);
      if (acc && n != 1 && exp_cnt < CNT_MAX) exp_cnt++;
      if (exp_q.size() > 0 && bus.Encoded_Ready_In) void'(exp_q.pop_front());
      if (do_push) exp_q.push_back(c);
      if (exp_q.size() > 0) last_val = exp_q[0];
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("ready", bus.Data_Ready_Out, (!rst && exp_q.size() < DEPTH));
      check("valid", bus.Encoded_Valid_Out, (exp_q.size() != 0));
      check("value", bus.Encoded_Value_Out, last_val);
      check("level", bus.Fifo_Level_Out, exp_q.size());
      check("multi_hot", bus.Multi_Hot_Out, exp_multi);
      check("zero_hot", bus.Zero_Hot_Out, exp_zero);
      check("err_count", bus.Error_Count_Out, exp_cnt);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // abcd: bit 3 = line A ... bit 0 = line D
  task automatic set_in(input bit v, input bit [3:0] abcd);
    bus.Data_Valid_In = v;
    bus.Data_A_In     = abcd[3];
    bus.Data_B_In     = abcd[2];
    bus.Data_C_In     = abcd[1];
    bus.Data_D_In     = abcd[0];
  endtask

  // {valid, A, B, C, D, downstream ready}
  logic [5:0] tbl [16] = '{
    6'b1_1000_1, 6'b1_0110_0, 6'b1_0001_0, 6'b0_0000_1,
    6'b1_0000_1, 6'b1_0010_1, 6'b1_1111_0, 6'b1_0100_0,
    6'b1_0011_0, 6'b1_1000_0, 6'b1_0001_1, 6'b0_1000_1,
    6'b1_0100_1, 6'b1_0010_0, 6'b0_0000_1, 6'b0_0000_1
  };

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    errors++;
    $display("FAIL timeout: simulation did not complete");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

  // ---------------- directed sequence ----------------
  initial begin
    set_in(1'b0, 4'b0000);
    bus.Encoded_Ready_In = 1'b0;
    rst = 1'b1;
    step();
    chk_en = 1'b1;
    step();
    check("rst_ready_low", bus.Data_Ready_Out, 0);
    check("rst_level", bus.Fifo_Level_Out, 0);
    check("rst_valid", bus.Encoded_Valid_Out, 0);
    check("rst_value", bus.Encoded_Value_Out, 0);
    check("rst_count", bus.Error_Count_Out, 0);
    rst = 1'b0;
    #1;
    check("ready_after_rst", bus.Data_Ready_Out, 1);

    // one-hot walk, each code presented one cycle after its push
    bus.Encoded_Ready_In = 1'b1;
    set_in(1'b1, 4'b1000); step(); check("walk_a", bus.Encoded_Value_Out, 0);
    check("walk_a_valid", bus.Encoded_Valid_Out, 1);
    set_in(1'b1, 4'b0100); step(); check("walk_b", bus.Encoded_Value_Out, 1);
    set_in(1'b1, 4'b0010); step(); check("walk_c", bus.Encoded_Value_Out, 2);
    set_in(1'b1, 4'b0001); step(); check("walk_d", bus.Encoded_Value_Out, 3);
    check("walk_count", bus.Error_Count_Out, 0);
    set_in(1'b0, 4'b0000); step();
    check("walk_empty", bus.Encoded_Valid_Out, 0);
    check("walk_hold", bus.Encoded_Value_Out, 3);

    // backpressure: fill, hold a fifth sample, then drain
    bus.Encoded_Ready_In = 1'b0;
    set_in(1'b1, 4'b1000); step();
    set_in(1'b1, 4'b0100); step();
    set_in(1'b1, 4'b0010); step();
    set_in(1'b1, 4'b0001); step();
    check("bp_full_level", bus.Fifo_Level_Out, 4);
    check("bp_ready_low", bus.Data_Ready_Out, 0);
    set_in(1'b1, 4'b0100);
    step(); step();
    check("bp_hold_level", bus.Fifo_Level_Out, 4);
    bus.Encoded_Ready_In = 1'b1;
    step();
    check("bp_pop_no_push", bus.Fifo_Level_Out, 3);
    check("bp_head_b", bus.Encoded_Value_Out, 1);
    step();
    check("bp_fifth_in", bus.Fifo_Level_Out, 3);
    check("bp_head_c", bus.Encoded_Value_Out, 2);
    set_in(1'b0, 4'b0000);
    step(); check("bp_head_d", bus.Encoded_Value_Out, 3);
    step(); check("bp_head_fifth", bus.Encoded_Value_Out, 1);
    step(); check("bp_drained", bus.Fifo_Level_Out, 0);

    // multi-hot B+D into an empty FIFO, downstream not taking codes
    bus.Encoded_Ready_In = 1'b0;
    set_in(1'b1, 4'b0101); step();
    check("mh_pulse", bus.Multi_Hot_Out, 1);
    check("mh_count", bus.Error_Count_Out, 1);
    check("mh_level", bus.Fifo_Level_Out, MH_LVL);
`ifndef STRICT_ONEHOT_EN
    check("mh_code", bus.Encoded_Value_Out, 1);
`endif
    bus.Encoded_Ready_In = 1'b1;
    set_in(1'b0, 4'b0000); step();
    check("mh_pulse_end", bus.Multi_Hot_Out, 0);

    // zero-hot samples, then run the counter into saturation
    set_in(1'b1, 4'b0000); step();
    check("zh_pulse", bus.Zero_Hot_Out, 1);
    check("zh_count", bus.Error_Count_Out, 2);
    check("zh_level", bus.Fifo_Level_Out, 0);
    check("zh_ready", bus.Data_Ready_Out, 1);
    for (int i = 0; i < 260; i++) step();
    check("sat_count", bus.Error_Count_Out, 255);
    step();
    check("sat_hold", bus.Error_Count_Out, 255);
    set_in(1'b0, 4'b0000); step();
    check("zh_pulse_end", bus.Zero_Hot_Out, 0);

    // reset with three codes buffered
    bus.Encoded_Ready_In = 1'b0;
    set_in(1'b1, 4'b1000); step();
    set_in(1'b1, 4'b0100); step();
    set_in(1'b1, 4'b0001); step();
    check("mr_level3", bus.Fifo_Level_Out, 3);
    set_in(1'b0, 4'b0000);
    rst = 1'b1; step(); rst = 1'b0;
    check("mr_level", bus.Fifo_Level_Out, 0);
    check("mr_valid", bus.Encoded_Valid_Out, 0);
    check("mr_count", bus.Error_Count_Out, 0);
    check("mr_value", bus.Encoded_Value_Out, 0);
    set_in(1'b1, 4'b0010); step();
    check("mr_push_c", bus.Encoded_Value_Out, 2);
    check("mr_push_valid", bus.Encoded_Valid_Out, 1);
    set_in(1'b0, 4'b0000);
    bus.Encoded_Ready_In = 1'b1;
    step();

    // mixed vectors, checked cycle by cycle against the model
    for (int i = 0; i < 16; i++) begin
      set_in(tbl[i][5], tbl[i][4:1]);
      bus.Encoded_Ready_In = tbl[i][0];
      step();
    end
    set_in(1'b0, 4'b0000);
    bus.Encoded_Ready_In = 1'b1;
    for (int i = 0; i < 6; i++) step();
    check("final_empty", bus.Fifo_Level_Out, 0);

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/encoder_4_2_buffered.md
Name: encoder_4_2_buffered

Overview:
Registered 4-to-2 priority encoder, the inverse of the team's 2-4 decoder. It samples four one-hot data lines (A..D) under a valid/ready handshake and encodes them as A=00, B=01, C=10, D=11. Encoded codes are buffered in a small FIFO and presented downstream with their own valid/ready handshake. Non-one-hot inputs are flagged and counted. The block sits in front of any consumer of 2-bit select codes, e.g. a Decoder_2_4 feeding back to one-hot form.

Parameters:
FIFO_DEPTH, 4, number of buffered codes; power of 2, minimum 2
ERR_CNT_WIDTH, 8, width of the saturating error counter

Ports:
Clk_In  input  1  clock; all logic is rising-edge
Reset_In  input  1  synchronous, active-high reset
Data_Valid_In  input  1  upstream asserts that Data_*_In is valid this cycle
Data_Ready_Out  output  1  block can accept a sample this cycle
Data_A_In  input  1  one-hot line A, encodes to 2'b00
Data_B_In  input  1  one-hot line B, encodes to 2'b01
Data_C_In  input  1  one-hot line C, encodes to 2'b10
Data_D_In  input  1  one-hot line D, encodes to 2'b11
Encoded_Value_Out  output  2  code at the FIFO head
Encoded_Valid_Out  output  1  FIFO not empty
Encoded_Ready_In  input  1  downstream accepts Encoded_Value_Out this cycle
Multi_Hot_Out  output  1  one-cycle pulse: accepted sample had more than one line high
Zero_Hot_Out  output  1  one-cycle pulse: accepted sample had no line high
Error_Count_Out  output  ERR_CNT_WIDTH  saturating count of multi-hot plus zero-hot events
Fifo_Level_Out  output  clog2(FIFO_DEPTH)+1  current number of buffered entries

Behaviour:
- Clock and reset: one clock, Clk_In; reset is synchronous and active-high on Reset_In.
- Reset: on any cycle with Reset_In high, at the next edge:
  - FIFO pointers and level are cleared; Encoded_Valid_Out=0, Encoded_Value_Out=2'b00.
  - Multi_Hot_Out=0, Zero_Hot_Out=0, Error_Count_Out=0.
  - Data_Ready_Out=0 during the reset cycle only, 1 afterwards.
  - Reset mid-transfer discards all buffered codes.
- Handshakes:
  - Push when Data_Valid_In && Data_Ready_Out.
  - Pop when Encoded_Valid_Out && Encoded_Ready_In.
  - Data_Ready_Out = !full; it is combinational from the level and does not depend on Encoded_Ready_In.
  - When full, a simultaneous pop does not admit a push in the same cycle.
- Priority encode, highest priority first: A > B > C > D.
- Multi-hot sample:
  - The highest-priority line's code is pushed.
  - Multi_Hot_Out pulses for one cycle, the cycle after the push.
  - Error_Count_Out increments.
- Zero-hot sample (valid with no line high):
  - The handshake completes (the sample is consumed) but nothing is pushed.
  - Zero_Hot_Out pulses the following cycle; Error_Count_Out increments.
- Error_Count_Out saturates at all-ones and never wraps.
- Latency: a code pushed at edge N is visible on Encoded_Value_Out with Encoded_Valid_Out=1 after edge N. This gives one-cycle latency into an empty FIFO; there is no bypass.
- Output stability: Encoded_Value_Out and Encoded_Valid_Out change only on a pop, on a push into an empty FIFO, or on reset. A presented code must hold while Encoded_Ready_In=0.
- Simultaneous push and pop with 0 < level < DEPTH: level unchanged, order preserved.
- Pointers wrap modulo FIFO_DEPTH. Fifo_Level_Out ranges 0..FIFO_DEPTH.
- Outputs when empty: Encoded_Value_Out holds its last value. Consumers must qualify it with Encoded_Valid_Out.
- Underflow and overflow are impossible by construction.

Optional Feature:
STRICT_ONEHOT_EN
- Defined: multi-hot samples are consumed and flagged, but nothing is pushed. This matches the zero-hot handling.
- Undefined: multi-hot samples push the priority-encoded code, as described above.
- Multi_Hot_Out and Error_Count_Out behave identically in both builds.

Test Plan:
- Reset then one-hot walk: push A, B, C, D on 4 consecutive cycles with Encoded_Ready_In=1 -> outputs 00, 01, 10, 11 on cycles 1-4; no error pulses; Error_Count_Out=0.
- Backpressure: Encoded_Ready_In=0, push 5 samples with FIFO_DEPTH=4 -> Data_Ready_Out drops after the 4th; Fifo_Level_Out=4; the 5th sample is held by upstream. Then raise ready -> codes drain in order, and the 5th is accepted the cycle after level<4.
- Multi-hot B+D -> code 01 pushed, Multi_Hot_Out pulse, count=1. With STRICT_ONEHOT_EN: no push, level stays 0, count=1.
- Zero-hot valid sample -> no push, Zero_Hot_Out pulse, count increments, Data_Ready_Out stays 1.
- Counter saturation: ERR_CNT_WIDTH=2, 5 zero-hot samples -> Error_Count_Out=3 and held.
- Reset mid-operation: level=3, assert Reset_In for 1 cycle -> level=0, Encoded_Valid_Out=0, count=0. Next push of C -> 10 after one cycle.
